// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the instruction/data RAM port arbiter:
// op_code constants, FSM state encoding and requester-select encoding.
package mem_port_arbiter_pkg;

    localparam logic [3:0] OP_ADR = 4'b1100;
    localparam logic [3:0] OP_LDR = 4'b1101;
    localparam logic [3:0] OP_STR = 4'b1110;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2
    } state_t;

    typedef enum logic {
        SEL_IF = 1'b0,
        SEL_D  = 1'b1
    } sel_t;

    // Only loads and stores touch the RAM; everything else is answered with an error.
    function automatic logic op_supported(input logic [3:0] op);
        return (op == OP_LDR) || (op == OP_STR);
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between the fetch and data requesters.
// A requester whose ack is currently high is not eligible, so a request
// still held during its own ack cycle is not serviced twice.
// Optional macro MEM_ARB_RR_EN: round-robin on ties using the last-grant
// pointer; otherwise data always beats fetch on a tie.
module mem_arb_pick
    import mem_port_arbiter_pkg::*;
(
    input  logic if_req,
    input  logic if_ack,
    input  logic d_req,
    input  logic d_ack,
`ifdef MEM_ARB_RR_EN
    input  sel_t last_sel,
`endif
    output logic grant_valid,
    output sel_t grant_sel
);

    logic if_elig;
    logic d_elig;

    assign if_elig = if_req & ~if_ack;
    assign d_elig  = d_req & ~d_ack;

    // Pick a winner among the eligible requesters.
    always_comb begin
        grant_valid = if_elig | d_elig;
        grant_sel   = SEL_IF;
        if (if_elig && d_elig) begin
`ifdef MEM_ARB_RR_EN
            grant_sel = (last_sel == SEL_D) ? SEL_IF : SEL_D;
`else
            grant_sel = SEL_D;
`endif
        end else if (d_elig) begin
            grant_sel = SEL_D;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-port synchronous RAM between the instruction-fetch
// port and the LDR/STR data port. Each access takes IDLE -> ACCESS -> WAIT,
// with the ack (and read data) registered on the edge leaving WAIT.
// Optional macro MEM_ARB_RR_EN: round-robin tie-breaking instead of
// fixed data-over-fetch priority.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              d_req,
    input  logic [3:0]        d_op,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              d_err,
    output logic [ADDR_W-1:0] address_out,
    output logic [DATA_W-1:0] RAM_in,
    input  logic [DATA_W-1:0] RAM_out,
    output logic              RW,
    output logic              RAM_en,
    output logic              busy
);

    state_t            state_reg, state_next;
    sel_t              sel_reg, sel_next;
    logic              read_reg, read_next;
    logic              err_reg, err_next;
    logic [ADDR_W-1:0] address_reg, address_next;
    logic [DATA_W-1:0] ram_in_reg, ram_in_next;
    logic              rw_reg, rw_next;
    logic              ram_en_reg, ram_en_next;
    logic              busy_reg, busy_next;
    logic [DATA_W-1:0] if_rdata_reg, if_rdata_next;
    logic [DATA_W-1:0] d_rdata_reg, d_rdata_next;
    logic              if_ack_reg, if_ack_next;
    logic              d_ack_reg, d_ack_next;
    logic              d_err_reg, d_err_next;

    logic              grant_valid;
    sel_t              grant_sel;

`ifdef MEM_ARB_RR_EN
    sel_t              last_sel_reg, last_sel_next;
`endif

    mem_arb_pick u_pick (
        .if_req      (if_req),
        .if_ack      (if_ack_reg),
        .d_req       (d_req),
        .d_ack       (d_ack_reg),
`ifdef MEM_ARB_RR_EN
        .last_sel    (last_sel_reg),
`endif
        .grant_valid (grant_valid),
        .grant_sel   (grant_sel)
    );

    // Next-state and next-output logic; strobes default low, RW defaults to read.
    always_comb begin
        state_next    = state_reg;
        sel_next      = sel_reg;
        read_next     = read_reg;
        err_next      = err_reg;
        address_next  = address_reg;
        ram_in_next   = ram_in_reg;
        rw_next       = 1'b1;
        ram_en_next   = 1'b0;
        if_rdata_next = if_rdata_reg;
        d_rdata_next  = d_rdata_reg;
        if_ack_next   = 1'b0;
        d_ack_next    = 1'b0;
        d_err_next    = 1'b0;
`ifdef MEM_ARB_RR_EN
        last_sel_next = last_sel_reg;
`endif
        unique case (state_reg)
            ST_IDLE: begin
                if (grant_valid) begin
                    state_next = ST_ACCESS;
                    sel_next   = grant_sel;
`ifdef MEM_ARB_RR_EN
                    last_sel_next = grant_sel;
`endif
                    if (grant_sel == SEL_D) begin
                        err_next  = ~op_supported(d_op);
                        read_next = (d_op == OP_LDR);
                        if (op_supported(d_op)) begin
                            // The RAM strobe, address and direction are set up on
                            // the grant edge so they are valid throughout ACCESS.
                            ram_en_next  = 1'b1;
                            address_next = d_addr;
                            rw_next      = (d_op != OP_STR);
                            if (d_op == OP_STR) begin
                                ram_in_next = d_wdata;
                            end
                        end
                    end else begin
                        err_next     = 1'b0;
                        read_next    = 1'b1;
                        ram_en_next  = 1'b1;
                        address_next = if_addr;
                    end
                end
            end
            ST_ACCESS: begin
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                // RAM_out carries the read word during this cycle.
                state_next = ST_IDLE;
                if (sel_reg == SEL_IF) begin
                    if_ack_next   = 1'b1;
                    if_rdata_next = RAM_out;
                end else begin
                    d_ack_next = 1'b1;
                    d_err_next = err_reg;
                    if (read_reg) begin
                        d_rdata_next = RAM_out;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
        busy_next = (state_next != ST_IDLE);
    end

    // State and registered outputs; reset abandons any access in flight.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg    <= ST_IDLE;
            sel_reg      <= SEL_IF;
            read_reg     <= 1'b0;
            err_reg      <= 1'b0;
            address_reg  <= '0;
            ram_in_reg   <= '0;
            rw_reg       <= 1'b1;
            ram_en_reg   <= 1'b0;
            busy_reg     <= 1'b0;
            if_rdata_reg <= '0;
            d_rdata_reg  <= '0;
            if_ack_reg   <= 1'b0;
            d_ack_reg    <= 1'b0;
            d_err_reg    <= 1'b0;
`ifdef MEM_ARB_RR_EN
            last_sel_reg <= SEL_IF;
`endif
        end else begin
            state_reg    <= state_next;
            sel_reg      <= sel_next;
            read_reg     <= read_next;
            err_reg      <= err_next;
            address_reg  <= address_next;
            ram_in_reg   <= ram_in_next;
            rw_reg       <= rw_next;
            ram_en_reg   <= ram_en_next;
            busy_reg     <= busy_next;
            if_rdata_reg <= if_rdata_next;
            d_rdata_reg  <= d_rdata_next;
            if_ack_reg   <= if_ack_next;
            d_ack_reg    <= d_ack_next;
            d_err_reg    <= d_err_next;
`ifdef MEM_ARB_RR_EN
            last_sel_reg <= last_sel_next;
`endif
        end
    end

    assign if_rdata    = if_rdata_reg;
    assign if_ack      = if_ack_reg;
    assign d_rdata     = d_rdata_reg;
    assign d_ack       = d_ack_reg;
    assign d_err       = d_err_reg;
    assign address_out = address_reg;
    assign RAM_in      = ram_in_reg;
    assign RW          = rw_reg;
    assign RAM_en      = ram_en_reg;
    assign busy        = busy_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: a RAM model with one-cycle registered read,
// a separate expected-memory model, and per-scenario tasks with inline checks.
// Honours MEM_ARB_RR_EN for the expected grant order under contention.
module tb_mem_port_arbiter;

    localparam logic [3:0] T_ADR = 4'b1100;
    localparam logic [3:0] T_LDR = 4'b1101;
    localparam logic [3:0] T_STR = 4'b1110;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        d_req;
    logic [3:0]  d_op;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ack;
    logic        d_err;
    logic [31:0] address_out;
    logic [31:0] RAM_in;
    logic [31:0] RAM_out;
    logic        RW;
    logic        RAM_en;
    logic        busy;

    always #5 Clk = ~Clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .if_req      (if_req),
        .if_addr     (if_addr),
        .if_rdata    (if_rdata),
        .if_ack      (if_ack),
        .d_req       (d_req),
        .d_op        (d_op),
        .d_addr      (d_addr),
        .d_wdata     (d_wdata),
        .d_rdata     (d_rdata),
        .d_ack       (d_ack),
        .d_err       (d_err),
        .address_out (address_out),
        .RAM_in      (RAM_in),
        .RAM_out     (RAM_out),
        .RW          (RW),
        .RAM_en      (RAM_en),
        .busy        (busy)
    );

    // Environment RAM: registered read, write on strobe, bench preload port.
    logic [31:0] ram [0:255];
    logic        pre_we;
    logic [7:0]  pre_addr;
    logic [31:0] pre_data;

    always @(posedge Clk) begin
        if (pre_we) begin
            ram[pre_addr] <= pre_data;
        end else if (RAM_en) begin
            if (RW) RAM_out <= ram[address_out[7:0]];
            else    ram[address_out[7:0]] <= RAM_in;
        end
    end

    // Expected state
    logic [31:0] model_mem [0:255];
    logic [31:0] exp_if_rdata;
    logic [31:0] exp_d_rdata;
    int total = 0;
    int bad   = 0;

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic set_word(input logic [7:0] a, input logic [31:0] v);
        pre_we = 1'b1; pre_addr = a; pre_data = v;
        model_mem[a] = v;
        tick;
        pre_we = 1'b0;
    endtask

    // Drive one request, wait (bounded) for its ack, record what the RAM saw.
    task automatic do_req(input bit use_d, input logic [3:0] op, input logic [31:0] addr,
                          input logic [31:0] wdata, output int lat, output int en_cnt,
                          output logic [31:0] s_addr, output logic s_rw,
                          output logic [31:0] s_wd, output logic s_err,
                          output logic [31:0] s_rdata, output logic s_ack_after);
        lat = -1; en_cnt = 0; s_addr = '0; s_rw = 1'b1; s_wd = '0;
        s_err = 1'b0; s_rdata = '0; s_ack_after = 1'b0;
        if (use_d) begin
            d_req = 1'b1; d_op = op; d_addr = addr; d_wdata = wdata;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        for (int c = 1; c <= 20; c++) begin
            tick;
            if (RAM_en) begin
                en_cnt++; s_addr = address_out; s_rw = RW; s_wd = RAM_in;
            end
            if (use_d ? d_ack : if_ack) begin
                lat = c; s_err = d_err; s_rdata = use_d ? d_rdata : if_rdata;
                break;
            end
        end
        d_req = 1'b0; if_req = 1'b0;
        tick;
        s_ack_after = if_ack | d_ack;
    endtask

    task automatic test_reset;
        logic [5:0] v;
        Reset = 1'b1; if_req = 1'b0; d_req = 1'b0; pre_we = 1'b0;
        if_addr = '0; d_op = T_LDR; d_addr = '0; d_wdata = '0;
        for (int i = 0; i < 256; i++) set_word(i[7:0], $urandom);
        tick;
        Reset = 1'b0;
        exp_if_rdata = '0; exp_d_rdata = '0;
        for (int i = 0; i < 5; i++) begin
            tick;
            v = {if_ack, d_ack, d_err, RAM_en, busy, RW};
            total++;
            if (v !== 6'b000001) begin
                bad++;
                $display("FAIL reset_idle cycle %0d: {if_ack,d_ack,d_err,RAM_en,busy,RW}=%b want 000001", i, v);
            end
        end
        total++;
        if ({address_out, RAM_in, if_rdata, d_rdata} !== 128'd0) begin
            bad++;
            $display("FAIL reset_regs: addr=%h ram_in=%h if_rdata=%h d_rdata=%h want all 0",
                     address_out, RAM_in, if_rdata, d_rdata);
        end
        $display("reset: idle checks done");
    endtask

    task automatic test_fetch;
        int lat, en; logic [31:0] sa, sw, sr; logic srw, se, sack;
        set_word(8'h10, 32'hDEADBEEF);
        do_req(1'b0, T_LDR, 32'h10, 32'h0, lat, en, sa, srw, sw, se, sr, sack);
        exp_if_rdata = 32'hDEADBEEF;
        $display("fetch addr=10 lat=%0d rdata=%h", lat, sr);
        total++;
        if (lat !== 3) begin bad++; $display("FAIL fetch_latency: got %0d want 3", lat); end
        total++;
        if (en !== 1 || sa !== 32'h10 || srw !== 1'b1) begin
            bad++; $display("FAIL fetch_strobe: en_cnt=%0d addr=%h rw=%b want 1/10/1", en, sa, srw);
        end
        total++;
        if (sr !== 32'hDEADBEEF) begin bad++; $display("FAIL fetch_rdata: got %h want deadbeef", sr); end
        total++;
        if (sack !== 1'b0) begin bad++; $display("FAIL fetch_ack_width: ack still high next cycle"); end
    endtask

    task automatic test_store_load;
        int lat, en; logic [31:0] sa, sw, sr; logic srw, se, sack;
        do_req(1'b1, T_STR, 32'h20, 32'h12345678, lat, en, sa, srw, sw, se, sr, sack);
        model_mem[8'h20] = 32'h12345678;
        $display("store addr=20 wdata=12345678 lat=%0d", lat);
        total++;
        if (lat !== 3 || en !== 1 || sa !== 32'h20 || srw !== 1'b0 || sw !== 32'h12345678) begin
            bad++;
            $display("FAIL store_strobe: lat=%0d en=%0d addr=%h rw=%b wd=%h want 3/1/20/0/12345678",
                     lat, en, sa, srw, sw);
        end
        total++;
        if (se !== 1'b0 || sr !== exp_d_rdata) begin
            bad++; $display("FAIL store_resp: err=%b d_rdata=%h want 0/%h", se, sr, exp_d_rdata);
        end
        do_req(1'b1, T_LDR, 32'h20, 32'h0, lat, en, sa, srw, sw, se, sr, sack);
        exp_d_rdata = model_mem[8'h20];
        $display("load addr=20 lat=%0d rdata=%h", lat, sr);
        total++;
        if (lat !== 3 || se !== 1'b0 || sr !== 32'h12345678 || srw !== 1'b1) begin
            bad++; $display("FAIL load_resp: lat=%0d err=%b rdata=%h rw=%b want 3/0/12345678/1", lat, se, sr, srw);
        end
    endtask

    task automatic test_unsupported;
        int lat, en; logic [31:0] sa, sw, sr; logic srw, se, sack;
        do_req(1'b1, T_ADR, 32'h30, 32'h0, lat, en, sa, srw, sw, se, sr, sack);
        $display("unsupported op=1100 lat=%0d err=%b en_cnt=%0d", lat, se, en);
        total++;
        if (en !== 0 || lat !== 3 || se !== 1'b1) begin
            bad++; $display("FAIL unsupported_op: en=%0d lat=%0d err=%b want 0/3/1", en, lat, se);
        end
        total++;
        if (sr !== exp_d_rdata || sack !== 1'b0) begin
            bad++; $display("FAIL unsupported_hold: d_rdata=%h ack_after=%b want %h/0", sr, sack, exp_d_rdata);
        end
    endtask

    task automatic test_random;
        int lat, en; logic [31:0] sa, sw, sr; logic srw, se, sack;
        logic [3:0] ops [4];
        ops[0] = T_LDR; ops[1] = T_STR; ops[2] = T_ADR; ops[3] = 4'hF;
        for (int n = 0; n < 30; n++) begin
            bit use_d; logic [3:0] op; logic [7:0] a; logic [31:0] wd;
            bit supp; logic [31:0] want_rd;
            use_d = $urandom_range(0, 1) == 1;
            op    = ops[$urandom_range(0, 3)];
            a     = 8'($urandom_range(0, 255));
            wd    = $urandom;
            do_req(use_d, op, {24'd0, a}, wd, lat, en, sa, srw, sw, se, sr, sack);
            supp = !use_d || op == T_LDR || op == T_STR;
            if (!use_d) begin
                exp_if_rdata = model_mem[a]; want_rd = exp_if_rdata;
            end else begin
                if (op == T_LDR) exp_d_rdata = model_mem[a];
                if (op == T_STR) model_mem[a] = wd;
                want_rd = exp_d_rdata;
            end
            $display("rand %0d port=%s op=%b addr=%h lat=%0d rdata=%h err=%b",
                     n, use_d ? "D" : "IF", op, a, lat, sr, se);
            total++;
            if (lat !== 3 || en !== (supp ? 1 : 0) || se !== !supp || sack !== 1'b0) begin
                bad++;
                $display("FAIL rand_ctrl %0d: lat=%0d en=%0d err=%b ack_after=%b want 3/%0d/%b/0",
                         n, lat, en, se, sack, supp ? 1 : 0, !supp);
            end
            total++;
            if (supp && (sa !== {24'd0, a} || srw !== !(use_d && op == T_STR) ||
                         (use_d && op == T_STR && sw !== wd))) begin
                bad++;
                $display("FAIL rand_ram %0d: addr=%h rw=%b wd=%h want %h/%b/%h",
                         n, sa, srw, sw, a, !(use_d && op == T_STR), wd);
            end
            total++;
            if (sr !== want_rd) begin
                bad++; $display("FAIL rand_rdata %0d: got %h want %h", n, sr, want_rd);
            end
        end
    endtask

    task automatic test_back_to_back;
        int lat, en; logic [31:0] sa, sw, sr; logic srw, se, sack;
        int nd, ni, n, cyc; logic [3:0] order; logic [3:0] want_order;
        logic [7:0] da, ia;
        do_req(1'b1, T_LDR, 32'h05, 32'h0, lat, en, sa, srw, sw, se, sr, sack);
        exp_d_rdata = model_mem[8'h05];
`ifdef MEM_ARB_RR_EN
        want_order = 4'b1010;
`else
        want_order = 4'b0101;
`endif
        da = 8'h40; ia = 8'h80;
        d_req = 1'b1; d_op = T_LDR; d_addr = {24'd0, da};
        if_req = 1'b1; if_addr = {24'd0, ia};
        nd = 2; ni = 2; n = 0; cyc = 0; order = '0;
        while (n < 4 && cyc < 60) begin
            tick; cyc++;
            if (d_ack) begin
                order[n] = 1'b1; n++; nd--;
                total++;
                if (d_rdata !== model_mem[da]) begin
                    bad++; $display("FAIL b2b_d_rdata: got %h want %h", d_rdata, model_mem[da]);
                end
                exp_d_rdata = model_mem[da];
                da = da + 8'd1; d_addr = {24'd0, da};
                if (nd == 0) d_req = 1'b0;
            end
            if (if_ack) begin
                order[n] = 1'b0; n++; ni--;
                total++;
                if (if_rdata !== model_mem[ia]) begin
                    bad++; $display("FAIL b2b_if_rdata: got %h want %h", if_rdata, model_mem[ia]);
                end
                exp_if_rdata = model_mem[ia];
                ia = ia + 8'd1; if_addr = {24'd0, ia};
                if (ni == 0) if_req = 1'b0;
            end
        end
        d_req = 1'b0; if_req = 1'b0;
        tick;
        $display("back_to_back grants=%0d order=%b cycles=%0d", n, order, cyc);
        total++;
        if (n !== 4) begin bad++; $display("FAIL b2b_timeout: grants=%0d want 4", n); end
        total++;
        if (order !== want_order) begin
            bad++; $display("FAIL b2b_order: got %b want %b (bit i = D for grant i)", order, want_order);
        end
        total++;
        if (cyc !== 12) begin bad++; $display("FAIL b2b_throughput: cycles=%0d want 12", cyc); end
    endtask

    task automatic test_reset_mid;
        logic seen_ack;
        if_req = 1'b1; if_addr = 32'h10;
        tick;
        total++;
        if (RAM_en !== 1'b1 || busy !== 1'b1) begin
            bad++; $display("FAIL midreset_access: RAM_en=%b busy=%b want 1/1", RAM_en, busy);
        end
        Reset = 1'b1; if_req = 1'b0;
        tick;
        Reset = 1'b0;
        total++;
        if (RAM_en !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL midreset_idle: RAM_en=%b busy=%b want 0/0", RAM_en, busy);
        end
        seen_ack = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick;
            seen_ack = seen_ack | if_ack | d_ack;
        end
        $display("reset mid-access: ack_seen=%b if_rdata=%h d_rdata=%h", seen_ack, if_rdata, d_rdata);
        total++;
        if (seen_ack !== 1'b0) begin bad++; $display("FAIL midreset_ack: ack seen=%b want 0", seen_ack); end
        total++;
        if (if_rdata !== 32'd0 || d_rdata !== 32'd0) begin
            bad++; $display("FAIL midreset_rdata: if=%h d=%h want 0/0", if_rdata, d_rdata);
        end
    endtask

    initial begin
        test_reset;
        test_fetch;
        test_store_load;
        test_unsupported;
        test_random;
        test_back_to_back;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
